// File: rtl/lcd_frame_writer.sv
// rtl/lcd_frame_writer.sv - HD44780 16x2 power-up/init sequencer and 32-char frame streamer
// Every LCD pin is registered from next-state values so the bus never glitches.
module lcd_frame_writer #(
    parameter int POWERUP_CYCLES = 750000,
    parameter int EN_CYCLES      = 25,
    parameter int WAIT_CYCLES    = 2500,
    parameter int CLEAR_CYCLES   = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] message,
    input  logic         refresh,
    output logic         busy,
    output logic         done,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_en,
    output logic [7:0]   lcd_data
);
    localparam logic [1:0] S_PWRUP = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_FRAME = 2'd3;

    localparam logic [31:0] PWR_LAST  = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] EN_LAST   = 32'(EN_CYCLES);
    localparam logic [31:0] NORM_LAST = 32'(EN_CYCLES + WAIT_CYCLES);
    localparam logic [31:0] CLR_LAST  = 32'(EN_CYCLES + CLEAR_CYCLES);

    logic [1:0]   state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [5:0]   idx_q, idx_d;
    logic         pend_q, pend_d;
    logic [255:0] frame_q, frame_d;
    logic         busy_q, done_q, en_q, rs_q;
    logic [7:0]   data_q;
    logic         done_d, en_d;
    logic [8:0]   cur_byte, nxt_byte;
    logic [31:0]  slot_last;

    // {rs, byte} carried by a given slot; FRAME slots 0 and 17 are the line addresses
    function automatic logic [8:0] slot_byte(input logic [1:0] st, input logic [5:0] idx,
                                             input logic [255:0] fr);
        logic [4:0] bi;
        slot_byte = 9'h000;
        bi        = 5'd0;
        if (st == S_INIT) begin
            case (idx[1:0])
                2'd0:    slot_byte = 9'h038;
                2'd1:    slot_byte = 9'h00C;
                2'd2:    slot_byte = 9'h001;
                default: slot_byte = 9'h006;
            endcase
        end else if (st == S_FRAME) begin
            if (idx == 6'd0) begin
                slot_byte = 9'h080;
            end else if (idx == 6'd17) begin
                slot_byte = 9'h0C0;
            end else begin
                bi        = (idx < 6'd17) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
                slot_byte = {1'b1, fr[{bi, 3'b000} +: 8]};
            end
        end
    endfunction

    assign cur_byte  = slot_byte(state_q, idx_q, frame_q);
    assign slot_last = (state_q == S_INIT && cur_byte == 9'h001) ? CLR_LAST : NORM_LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pend_d  = pend_q | refresh;
        frame_d = frame_q;
        done_d  = 1'b0;
        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = 32'd0;
                    idx_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_INIT: begin
                if (cnt_q == slot_last) begin
                    cnt_d = 32'd0;
                    if (idx_q == 6'd3) begin
                        state_d = S_IDLE;
                        idx_d   = 6'd0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_IDLE: begin
                if (pend_q || refresh) begin
                    state_d = S_FRAME;
                    cnt_d   = 32'd0;
                    idx_d   = 6'd0;
                    frame_d = message;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                if (cnt_q == slot_last) begin
                    cnt_d = 32'd0;
                    if (idx_q == 6'd33) begin
                        done_d = 1'b1;
                        idx_d  = 6'd0;
                        // a request seen on this very edge survives as the next pending flag
                        pend_d = refresh;
                        if (pend_q) begin
                            frame_d = message;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        endcase
    end

    assign nxt_byte = slot_byte(state_d, idx_d, frame_d);
    assign en_d     = ((state_d == S_INIT) || (state_d == S_FRAME)) &&
                      (cnt_d != 32'd0) && (cnt_d <= EN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_PWRUP;
            cnt_q   <= 32'd0;
            idx_q   <= 6'd0;
            pend_q  <= 1'b1;
            frame_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            frame_q <= frame_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            en_q    <= en_d;
            rs_q    <= nxt_byte[8];
            data_q  <= nxt_byte[7:0];
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = en_q;
    assign lcd_data = data_q;
endmodule
